// File: rtl/decim_output_formatter.sv
// Output formatter for the decimation filter: round/shift, saturate, and buffer in a valid/ready FIFO.
// Optional DC blocker ahead of saturation is enabled by defining DECIM_DC_BLOCK_EN.
module decim_output_formatter #(
   parameter int IN_WIDTH    = 32,
   parameter int OUT_WIDTH   = 16,
   parameter int SHIFT_WIDTH = 5,
   parameter int FIFO_DEPTH  = 8,
   parameter int DC_K        = 10
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   input  logic signed [IN_WIDTH-1:0]      in_data,
   input  logic [SHIFT_WIDTH-1:0]          shift,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic signed [OUT_WIDTH-1:0]     out_data,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            sat_flag,
   input  logic                            sat_clr,
   output logic [7:0]                      drop_count
);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = AW + 1;
   localparam int S1W = IN_WIDTH + 1;
`ifdef DECIM_DC_BLOCK_EN
   localparam int S2W = IN_WIDTH + 2;
`else
   localparam int S2W = S1W;
`endif
   localparam logic signed [S2W-1:0] SAT_MAX = {{(S2W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [S2W-1:0] SAT_MIN = {{(S2W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
   localparam logic [OUT_WIDTH-1:0]  OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0]  OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DC_K < 1) begin : g_bad_param
      $error("decim_output_formatter: FIFO_DEPTH must be a power of 2 >= 2 and DC_K >= 1");
   end

   // stage 1: round-half-up and arithmetic shift
   logic [31:0]            sh_amt;
   logic signed [S1W-1:0]  s1_ext, s1_rnd, s1_sum, s1_next, s1_data;
   logic                   s1_valid;

   always_comb begin
      sh_amt = 32'(shift);
      if (sh_amt >= 32'(IN_WIDTH)) sh_amt = 32'(IN_WIDTH - 1);
      s1_ext  = {in_data[IN_WIDTH-1], in_data};
      s1_rnd  = (S1W'(1) << sh_amt) >> 1;
      s1_sum  = s1_ext + s1_rnd;
      s1_next = s1_sum >>> sh_amt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) s1_data <= s1_next;
      end
   end

   // stage 2: optional DC blocker, then saturation
   logic signed [S2W-1:0]  sat_in;
`ifdef DECIM_DC_BLOCK_EN
   logic signed [S2W-1:0]  x_cur, x_prev, y_prev, dc_y;
   always_comb begin
      x_cur  = {s1_data[S1W-1], s1_data};
      dc_y   = x_cur - x_prev + y_prev - (y_prev >>> DC_K);
      sat_in = dc_y;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_prev <= '0;
         y_prev <= '0;
      end else if (s1_valid) begin
         x_prev <= x_cur;
         y_prev <= dc_y;
      end
   end
`else
   always_comb sat_in = s1_data;
`endif

   logic                   sat_hi, sat_lo, s2_valid;
   logic [OUT_WIDTH-1:0]   s2_next, s2_data;

   always_comb begin
      sat_hi  = sat_in > SAT_MAX;
      sat_lo  = sat_in < SAT_MIN;
      s2_next = sat_in[OUT_WIDTH-1:0];
      if (sat_hi) s2_next = OUT_MAX;
      else if (sat_lo) s2_next = OUT_MIN;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
         sat_flag <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) s2_data <= s2_next;
         // a clip in the same cycle as sat_clr keeps the flag set
         if (s1_valid && (sat_hi || sat_lo)) sat_flag <= 1'b1;
         else if (sat_clr) sat_flag <= 1'b0;
      end
   end

   // stage 3: FIFO with registered head
   logic [OUT_WIDTH-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr, rd_ptr, rd_next;
   logic [LW-1:0]          level, level_vis;
   logic                   pop, full, wr_acc, drop;

   always_comb begin
      pop       = out_valid & out_ready;
      full      = (level == LW'(FIFO_DEPTH));
      wr_acc    = s2_valid & (~full | pop);
      drop      = s2_valid & full & ~pop;
      rd_next   = rd_ptr + AW'(pop);
      // entries that were present before this edge and survive it; a fresh
      // write only reaches the head one cycle later (no fall-through)
      level_vis = level - LW'(pop);
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= s2_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         drop_count <= '0;
      end else begin
         wr_ptr    <= wr_ptr + AW'(wr_acc);
         rd_ptr    <= rd_next;
         level     <= level + LW'(wr_acc) - LW'(pop);
         out_valid <= (level_vis != '0);
         if (level_vis != '0) out_data <= mem[rd_next];
         if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
   end

   assign fifo_level = level;

endmodule
